// File: rtl/vector_fetch_if.sv
// Vector-list fetch bus: frame handshake, RAM read port and line-drawer handshake.
interface vector_fetch_if #(
  parameter int OUT_WIDTH = 8,
  parameter int ADR_WIDTH = 16,
  parameter int DATAWIDTH = 18
);
  logic                 draw_frame;
  logic                 frame_done;
  logic [ADR_WIDTH-1:0] adrREAD;
  logic [DATAWIDTH-1:0] dataREAD;
  logic                 line_start;
  logic [OUT_WIDTH-1:0] x0;
  logic [OUT_WIDTH-1:0] y0;
  logic [OUT_WIDTH-1:0] x1;
  logic [OUT_WIDTH-1:0] y1;
  logic                 line_done;

  // Fetch engine side.
  modport master (
    input  draw_frame, dataREAD, line_done,
    output frame_done, adrREAD, line_start, x0, y0, x1, y1
  );

  // Frame writer / RAM / line drawer side.
  modport slave (
    output draw_frame, dataREAD, line_done,
    input  frame_done, adrREAD, line_start, x0, y0, x1, y1
  );
endinterface

// File: rtl/vector_fetch.sv
// Walks a vector list in RAM (move / draw / no-op / end entries) and hands
// each draw entry to a line drawer as a pair of endpoints.
module vector_fetch #(
  parameter int OUT_WIDTH = 8,
  parameter int ADR_WIDTH = 16,
  parameter int DATAWIDTH = 18
) (
  input  logic           clk,
  input  logic           rst,
  vector_fetch_if.master bus,
  output logic [2:0]     state_debug
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    FETCH      = 3'd1,
    WAIT_DATA  = 3'd2,
    DECODE     = 3'd3,
    START_LINE = 3'd4,
    WAIT_LINE  = 3'd5,
    FINISH     = 3'd6
  } state_t;

  state_t               state;
  state_t               state_next;
  logic                 draw_prev;
  logic                 start;
  logic [OUT_WIDTH-1:0] cur_x;
  logic [OUT_WIDTH-1:0] cur_y;
  logic [OUT_WIDTH-1:0] ent_x;
  logic [OUT_WIDTH-1:0] ent_y;
  logic                 ent_line;
  logic                 ent_pos;
  logic                 is_end;
  logic                 is_draw;
  logic                 is_move;
  logic                 adr_last;

  assign ent_x    = bus.dataREAD[DATAWIDTH-1 -: OUT_WIDTH];
  assign ent_y    = bus.dataREAD[DATAWIDTH-OUT_WIDTH-1 -: OUT_WIDTH];
  assign ent_line = bus.dataREAD[1];
  assign ent_pos  = bus.dataREAD[0];
  assign is_end   = ent_line & ent_pos;
  assign is_draw  = ent_line & ~ent_pos;
  assign is_move  = ~ent_line & ent_pos;
  assign adr_last = &bus.adrREAD;
  assign start    = bus.draw_frame & ~draw_prev;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Next-state logic; a non-end entry at the last address ends the frame
  // (even a draw) so the address never wraps.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:       if (start) state_next = FETCH;
      FETCH:      state_next = WAIT_DATA;
      WAIT_DATA:  state_next = DECODE;
      DECODE: begin
        if (is_end || adr_last) state_next = FINISH;
        else if (is_draw)       state_next = START_LINE;
        else                    state_next = FETCH;
      end
      START_LINE: state_next = WAIT_LINE;
      WAIT_LINE:  if (bus.line_done) state_next = FETCH;
      FINISH:     state_next = IDLE;
      default:    state_next = IDLE;
    endcase
  end

  // Pulse outputs and state visibility.
  always_comb begin
    bus.line_start = (state == START_LINE);
    bus.frame_done = (state == FINISH);
    state_debug    = state;
  end

  // Address, current point, endpoint registers and draw_frame edge history.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      draw_prev   <= 1'b0;
      bus.adrREAD <= '0;
      cur_x       <= '0;
      cur_y       <= '0;
      bus.x0      <= '0;
      bus.y0      <= '0;
      bus.x1      <= '0;
      bus.y1      <= '0;
    end else begin
      draw_prev <= bus.draw_frame;
      case (state)
        IDLE: begin
          if (start) begin
            bus.adrREAD <= '0;
            cur_x       <= '0;
            cur_y       <= '0;
          end
        end
        DECODE: begin
          if (!is_end && !adr_last) begin
            if (is_draw) begin
              bus.x0 <= cur_x;
              bus.y0 <= cur_y;
              bus.x1 <= ent_x;
              bus.y1 <= ent_y;
            end else begin
              bus.adrREAD <= bus.adrREAD + ADR_WIDTH'(1);
              if (is_move) begin
                cur_x <= ent_x;
                cur_y <= ent_y;
              end
            end
          end
        end
        WAIT_LINE: begin
          if (bus.line_done) begin
            cur_x       <= bus.x1;
            cur_y       <= bus.y1;
            bus.adrREAD <= bus.adrREAD + ADR_WIDTH'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
